// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types and constants for the exec_core datapath
package exec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE
  } exec_state_t;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLL,
    OP_SRL,
    OP_SLT
  } alu_op_t;

  localparam logic MODE_IMM = 1'b0;
  localparam logic MODE_REG = 1'b1;

endpackage

// File: rtl/exec_core_if.sv
// rtl/exec_core_if.sv - instruction handshake and result bus of exec_core
interface exec_core_if #(
  parameter int WIDTH = 32,
  parameter int RA    = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [2:0]       opcode;
  logic [RA-1:0]    rd;
  logic [RA-1:0]    rs1;
  logic [RA-1:0]    rs2;
  logic [11:0]      imm12;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [RA-1:0]    out_rd;

  modport master (
    output in_valid, mode, opcode, rd, rs1, rs2, imm12,
    input  in_ready, out_valid, out_data, out_rd
  );

  modport slave (
    input  in_valid, mode, opcode, rd, rs1, rs2, imm12,
    output in_ready, out_valid, out_data, out_rd
  );
endinterface

// File: rtl/exec_core_alu.sv
// rtl/exec_core_alu.sv - combinational ALU, all results modulo 2^WIDTH
module exec_alu
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] shamt;
  logic          lt;

  assign shamt = b[SW-1:0];
  assign lt    = $signed(a) < $signed(b);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << shamt;
      OP_SRL:  y = a >> shamt;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, lt};
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/exec_core.sv
// rtl/exec_core.sv - 4-state RV32-style execute core with register file and result bus
module exec_core
  import exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int RA    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  exec_core_if.slave       bus,
  input  logic [RA-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [7:0]       led
);
  exec_state_t      state, state_nxt;
  logic             accept, load_ops, load_res, wr_en;
  logic             mode_q;
  alu_op_t          op_q;
  logic [RA-1:0]    rd_q, rs1_q, rs2_q;
  logic [11:0]      imm_q;
  logic [WIDTH-1:0] imm_sext, opnd_b, op_a, op_b, alu_y, res_q;
  logic [RA-1:0]    res_rd_q;
  logic [WIDTH-1:0] regs [NREGS];

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    load_ops      = 1'b0;
    load_res      = 1'b0;
    case (state)
      ST_IDLE:  bus.in_ready  = 1'b1;
      ST_READ:  load_ops      = 1'b1;
      ST_EXEC:  load_res      = 1'b1;
      ST_WRITE: bus.out_valid = 1'b1;
      default:  ;
    endcase
  end

  // rs2 is zeroed in immediate mode so an undriven field never reaches the datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_IMM;
      op_q   <= OP_ADD;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
    end else if (accept) begin
      mode_q <= bus.mode;
      op_q   <= alu_op_t'(bus.opcode);
      rd_q   <= bus.rd;
      rs1_q  <= bus.rs1;
      rs2_q  <= (bus.mode == MODE_REG) ? bus.rs2 : '0;
      imm_q  <= bus.imm12;
    end
  end

  assign imm_sext = WIDTH'($signed(imm_q));
  assign opnd_b   = (mode_q == MODE_REG) ? regs[rs2_q] : imm_sext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a <= '0;
      op_b <= '0;
    end else if (load_ops) begin
      op_a <= regs[rs1_q];
      op_b <= opnd_b;
    end
  end

  exec_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op_q),
    .a  (op_a),
    .b  (op_b),
    .y  (alu_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q    <= '0;
      res_rd_q <= '0;
    end else if (load_res) begin
      res_q    <= alu_y;
      res_rd_q <= rd_q;
    end
  end

  // register 0 is never written, so every read of it returns 0
  assign wr_en = (state == ST_WRITE) && (rd_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd_q] <= res_q;
    end
  end

  assign bus.out_data = res_q;
  assign bus.out_rd   = res_rd_q;
  assign led          = res_q[7:0];
  assign dbg_data     = (dbg_addr == '0) ? '0 : regs[dbg_addr];
endmodule

// File: tb/tb_exec_core.sv
// tb/tb_exec_core.sv - directed vector bench for exec_core
module tb_exec_core;
  import exec_pkg::*;

  typedef struct {
    logic        mode;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic [7:0]  led;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic        watch_ov = 1'b0;
  logic        seen_ov = 1'b0;
  vec_t        vecs [13];
  vec_t        prog [3];
  logic [31:0] bexp [3];

  exec_core_if #(.WIDTH(32), .RA(5)) bus ();

  exec_core #(.WIDTH(32), .NREGS(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .led      (led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (watch_ov && bus.out_valid) seen_ov = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive(input vec_t v, input logic valid);
    bus.in_valid = valid;
    bus.mode     = v.mode;
    bus.opcode   = v.op;
    bus.rd       = v.rd;
    bus.rs1      = v.rs1;
    bus.rs2      = v.rs2;
    bus.imm12    = v.imm;
  endtask

  task automatic dbg_read(input logic [4:0] a, output logic [31:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  initial begin
    vec_t        junk;
    logic [31:0] d;
    junk = '{1'b1, 3'd1, 5'd31, 5'd30, 5'd29, 12'hABC, 32'h0};

    vecs[0]  = '{1'b0, OP_ADD, 5'd1,  5'd0, 5'd9,  12'h7FF, 32'h0000_07FF};
    vecs[1]  = '{1'b0, OP_ADD, 5'd2,  5'd1, 5'd31, 12'h800, 32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, OP_SUB, 5'd3,  5'd0, 5'd1,  12'h000, 32'hFFFF_F801};
    vecs[3]  = '{1'b1, OP_SLT, 5'd4,  5'd3, 5'd0,  12'h000, 32'h0000_0001};
    vecs[4]  = '{1'b0, OP_SRL, 5'd5,  5'd2, 5'd7,  12'h03F, 32'h0000_0001};
    vecs[5]  = '{1'b0, OP_ADD, 5'd0,  5'd0, 5'd3,  12'h005, 32'h0000_0005};
    vecs[6]  = '{1'b1, OP_AND, 5'd7,  5'd3, 5'd1,  12'h000, 32'h0000_0001};
    vecs[7]  = '{1'b0, OP_OR,  5'd8,  5'd1, 5'd2,  12'h800, 32'hFFFF_FFFF};
    vecs[8]  = '{1'b0, OP_XOR, 5'd9,  5'd3, 5'd4,  12'hFFF, 32'h0000_07FE};
    vecs[9]  = '{1'b0, OP_SLL, 5'd10, 5'd4, 5'd5,  12'h024, 32'h0000_0010};
    vecs[10] = '{1'b1, OP_SLT, 5'd11, 5'd4, 5'd3,  12'h000, 32'h0000_0000};
    vecs[11] = '{1'b0, OP_SLT, 5'd12, 5'd3, 5'd6,  12'h800, 32'h0000_0000};
    vecs[12] = '{1'b0, OP_SUB, 5'd13, 5'd0, 5'd8,  12'h001, 32'hFFFF_FFFF};

    prog[0] = '{1'b0, OP_ADD, 5'd13, 5'd1,  5'd0,  12'h001, 32'h0};
    prog[1] = '{1'b1, OP_ADD, 5'd14, 5'd13, 5'd13, 12'h000, 32'h0};
    prog[2] = '{1'b0, OP_SUB, 5'd15, 5'd14, 5'd0,  12'h800, 32'h0};
    bexp[0] = 32'h0000_0800;
    bexp[1] = 32'h0000_1000;
    bexp[2] = 32'h0000_1800;

    drive(junk, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_out_rd", {27'b0, bus.out_rd}, 32'd0);
    chk("reset_led", {24'b0, led}, 32'd0);
    for (int r = 0; r < 32; r++) begin
      dbg_read(5'(r), d);
      chk($sformatf("reset_reg%0d", r), d, 32'd0);
    end

    for (int i = 0; i < 13; i++) begin
      chk($sformatf("v%0d_ready_before", i), {31'b0, bus.in_ready}, 32'd1);
      drive(vecs[i], 1'b1);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (k == 0) drive(junk, 1'b0);
        chk($sformatf("v%0d_out_valid_k%0d", i, k), {31'b0, bus.out_valid}, (k == 2) ? 32'd1 : 32'd0);
        chk($sformatf("v%0d_in_ready_k%0d", i, k), {31'b0, bus.in_ready}, (k == 3) ? 32'd1 : 32'd0);
        if (k == 2) begin
          chk($sformatf("v%0d_out_data", i), bus.out_data, vecs[i].exp);
          chk($sformatf("v%0d_out_rd", i), {27'b0, bus.out_rd}, {27'b0, vecs[i].rd});
          chk($sformatf("v%0d_led", i), {24'b0, led}, {24'b0, vecs[i].exp[7:0]});
        end
        if (k == 3) begin
          dbg_read(vecs[i].rd, d);
          chk($sformatf("v%0d_reg", i), d, (vecs[i].rd == 5'd0) ? 32'd0 : vecs[i].exp);
        end
      end
    end

    for (int c = 0; c < 12; c++) begin
      chk($sformatf("b2b_in_ready_c%0d", c), {31'b0, bus.in_ready}, (c % 4 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_out_valid_c%0d", c), {31'b0, bus.out_valid}, (c % 4 == 3) ? 32'd1 : 32'd0);
      if (c % 4 == 3) chk($sformatf("b2b_out_data_c%0d", c), bus.out_data, bexp[c / 4]);
      if (c % 4 == 0) drive(prog[c / 4], 1'b1);
      else drive(junk, c != 11);
      @(negedge clk);
    end
    chk("b2b_idle_ready", {31'b0, bus.in_ready}, 32'd1);
    dbg_read(5'd13, d); chk("b2b_r13", d, bexp[0]);
    dbg_read(5'd14, d); chk("b2b_r14", d, bexp[1]);
    dbg_read(5'd15, d); chk("b2b_r15", d, bexp[2]);
    dbg_read(5'd31, d); chk("b2b_r31_untouched", d, 32'd0);

    drive('{1'b0, OP_ADD, 5'd6, 5'd1, 5'd0, 12'h001, 32'h0}, 1'b1);
    watch_ov = 1'b1;
    @(negedge clk);
    drive(junk, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    watch_ov = 1'b0;
    chk("rst_mid_no_out_valid", {31'b0, seen_ov}, 32'd0);
    chk("rst_mid_idle", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_mid_out_data", bus.out_data, 32'd0);
    dbg_read(5'd6, d); chk("rst_mid_r6", d, 32'd0);
    dbg_read(5'd1, d); chk("rst_mid_r1_cleared", d, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
